// File: rtl/controle_pilha.sv
// rtl/controle_pilha.sv - instruction sequencer for the 8-bit stack/temp/ALU datapath (optional feature macro: CTRL_CARRY_FLAG_EN)
module controle_pilha #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              done,
  output logic              err,
  output logic              stk_push,
  output logic              stk_pop,
  input  logic              stk_empty,
  input  logic              stk_full,
  input  logic [DATA_W-1:0] stk_dout,
  output logic [DATA_W-1:0] stk_din,
  output logic              ld_tmp1,
  output logic              ld_tmp2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_cout,
  output logic              carry_flag
);

  localparam logic [OP_W-1:0] OP_PUSHI   = OP_W'(5'h1F);
  localparam logic [OP_W-1:0] OP_DROP    = OP_W'(5'h1E);
  localparam logic [OP_W-1:0] OP_CLRC    = OP_W'(5'h1D);
  localparam logic [OP_W-1:0] OP_BIN_MAX = OP_W'(5'h0F);
  localparam logic [OP_W-1:0] OP_UN_MIN  = OP_W'(5'h10);
  localparam logic [OP_W-1:0] OP_UN_MAX  = OP_W'(5'h17);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSHI,
    S_POP_B,
    S_LD_B,
    S_POP_A,
    S_LD_A,
    S_EXEC,
    S_PUSH_R,
    S_DONE,
    S_ERR,
    S_CLRC
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   res_q;
  logic                accept;
  logic                in_is_bin, in_is_un;
  logic                op_is_bin;

  // stk_dout is consumed by the external temp registers, not by this sequencer
  logic unused_stk_dout;
  assign unused_stk_dout = ^stk_dout;

  assign accept    = instr_valid && (state_q == S_IDLE);
  assign in_is_bin = (instr_op <= OP_BIN_MAX);
  assign in_is_un  = (instr_op >= OP_UN_MIN) && (instr_op <= OP_UN_MAX);
  // Only binary ops fetch a second operand; unary ones skip straight to EXEC
  assign op_is_bin = (op_q <= OP_BIN_MAX);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction latch at accept, ALU result capture in EXEC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q  <= '0;
      imm_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= instr_op;
        imm_q <= instr_imm;
      end
      if (state_q == S_EXEC) begin
        res_q <= alu_res;
      end
    end
  end

`ifdef CTRL_CARRY_FLAG_EN
  logic carry_q;

  // Sticky carry: set by any ALU op producing carry, cleared only by CLRC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      carry_q <= 1'b0;
    end else if (state_q == S_CLRC) begin
      carry_q <= 1'b0;
    end else if ((state_q == S_EXEC) && alu_cout) begin
      carry_q <= 1'b1;
    end
  end

  assign carry_flag = carry_q;
`else
  logic unused_alu_cout;
  assign unused_alu_cout = alu_cout;
  assign carry_flag      = 1'b0;
`endif

  // Next-state decode and Moore outputs; push/pop are suppressed when the
  // stack cannot take them so a refused access never reaches the stack
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_din     = '0;
    ld_tmp1     = 1'b0;
    ld_tmp2     = 1'b0;
    alu_op      = op_q;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        alu_op      = '0;
        if (instr_valid) begin
          if (instr_op == OP_PUSHI) begin
            state_d = S_PUSHI;
          end else if (instr_op == OP_DROP || in_is_bin || in_is_un) begin
            state_d = S_POP_B;
`ifdef CTRL_CARRY_FLAG_EN
          end else if (instr_op == OP_CLRC) begin
            state_d = S_CLRC;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_PUSHI: begin
        stk_din = imm_q;
        if (stk_full) begin
          state_d = S_ERR;
        end else begin
          stk_push = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_POP_B: begin
        if (stk_empty) begin
          state_d = S_ERR;
        end else begin
          stk_pop = 1'b1;
          state_d = (op_q == OP_DROP) ? S_DONE : S_LD_B;
        end
      end
      S_LD_B: begin
        ld_tmp2 = 1'b1;
        state_d = op_is_bin ? S_POP_A : S_EXEC;
      end
      S_POP_A: begin
        if (stk_empty) begin
          state_d = S_ERR;
        end else begin
          stk_pop = 1'b1;
          state_d = S_LD_A;
        end
      end
      S_LD_A: begin
        ld_tmp1 = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_PUSH_R;
      end
      S_PUSH_R: begin
        stk_din = res_q;
        if (stk_full) begin
          state_d = S_ERR;
        end else begin
          stk_push = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_CLRC: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic unused_clrc;
  assign unused_clrc = ^OP_CLRC;

endmodule

// File: tb/tb_controle_pilha.sv
// tb/tb_controle_pilha.sv - table-driven bench for controle_pilha with stack, temp and ALU models
module tb_controle_pilha;

  localparam int DW    = 8;
  localparam int OW    = 5;
  localparam int DEPTH = 8;
`ifdef CTRL_CARRY_FLAG_EN
  localparam bit CF = 1'b1;
`else
  localparam bit CF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          instr_valid;
  logic          instr_ready;
  logic [OW-1:0] instr_op;
  logic [DW-1:0] instr_imm;
  logic          done, err;
  logic          stk_push, stk_pop, stk_empty, stk_full;
  logic [DW-1:0] stk_dout = '0;
  logic [DW-1:0] stk_din;
  logic          ld_tmp1, ld_tmp2;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_res;
  logic          alu_cout;
  logic          carry_flag;

  always #5 clk = ~clk;

  controle_pilha #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rstn(rstn),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm),
    .done(done), .err(err),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_empty(stk_empty), .stk_full(stk_full),
    .stk_dout(stk_dout), .stk_din(stk_din),
    .ld_tmp1(ld_tmp1), .ld_tmp2(ld_tmp2),
    .alu_op(alu_op), .alu_res(alu_res), .alu_cout(alu_cout),
    .carry_flag(carry_flag)
  );

  // Stack model with registered read data and protocol-violation counters
  logic [DW-1:0] mem [0:DEPTH-1];
  int   sp = 0;
  int   bad_push = 0, bad_pop = 0, both_cnt = 0;
  logic force_full = 1'b0;
  logic clr_stk = 1'b0;
  assign stk_empty = (sp == 0);
  assign stk_full  = force_full || (sp == DEPTH);

  always @(posedge clk) begin
    if (clr_stk) begin
      sp <= 0;
    end else begin
      if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
      if (stk_push) begin
        if (!stk_full) begin
          mem[sp] <= stk_din;
          sp <= sp + 1;
        end else begin
          bad_push <= bad_push + 1;
        end
      end else if (stk_pop) begin
        if (sp > 0) begin
          stk_dout <= mem[sp-1];
          sp <= sp - 1;
        end else begin
          bad_pop <= bad_pop + 1;
        end
      end
    end
  end

  // Operand registers and ALU model: 00 add, 01 sub, 10 increment temp2, else xor
  logic [DW-1:0] t1 = '0, t2 = '0;
  always @(posedge clk) begin
    if (ld_tmp1) t1 <= stk_dout;
    if (ld_tmp2) t2 <= stk_dout;
  end

  always @* begin
    {alu_cout, alu_res} = {1'b0, t1 ^ t2};
    case (alu_op)
      5'h00: {alu_cout, alu_res} = {1'b0, t1} + {1'b0, t2};
      5'h01: {alu_cout, alu_res} = {1'b0, t1} - {1'b0, t2};
      5'h10: {alu_cout, alu_res} = {1'b0, t2} + 9'd1;
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one instruction, wait for accept, then count cycles to done/err
  task automatic run(input logic [OW-1:0] op, input logic [DW-1:0] imm, input bit full,
                     output int lat, output bit got_done, output bit got_err);
    int w;
    @(negedge clk);
    force_full  = full;
    instr_op    = op;
    instr_imm   = imm;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", 32'(w < 20), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op    = 5'h1B;
    instr_imm   = 8'hAA;
    chk("busy_ready", 32'(instr_ready), 32'd0);
    chk("busy_alu_op", 32'(alu_op), 32'(op));
    lat = 1;
    while (!done && !err && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_done = done;
    got_err  = err;
    @(negedge clk);
    chk("pulse_end", 32'({done, err, instr_ready}), 32'b001);
    force_full = 1'b0;
  endtask

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] imm;
    bit            full;
    bit            exp_done;
    int            exp_lat;
    int            exp_depth;
    logic [DW-1:0] exp_top;
    logic [DW-1:0] exp_t1;
    logic [DW-1:0] exp_t2;
    bit            exp_c;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int  lat;
    bit  gd, ge;
    int  w;
    logic [3:0] exp_rdy, exp_err;

    tbl[0]  = '{5'h1F, 8'h05, 1'b0, 1'b1, 2, 1, 8'h05, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{5'h1F, 8'h03, 1'b0, 1'b1, 2, 2, 8'h03, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{5'h00, 8'h00, 1'b0, 1'b1, 7, 1, 8'h08, 8'h05, 8'h03, 1'b0};
    tbl[3]  = '{5'h10, 8'h00, 1'b0, 1'b1, 5, 1, 8'h09, 8'h05, 8'h08, 1'b0};
    tbl[4]  = '{5'h1E, 8'h00, 1'b0, 1'b1, 2, 0, 8'h00, 8'h05, 8'h08, 1'b0};
    tbl[5]  = '{5'h00, 8'h00, 1'b0, 1'b0, 2, 0, 8'h00, 8'h05, 8'h08, 1'b0};
    tbl[6]  = '{5'h1F, 8'h07, 1'b0, 1'b1, 2, 1, 8'h07, 8'h05, 8'h08, 1'b0};
    tbl[7]  = '{5'h01, 8'h00, 1'b0, 1'b0, 4, 0, 8'h00, 8'h05, 8'h07, 1'b0};
    tbl[8]  = '{5'h1F, 8'h11, 1'b1, 1'b0, 2, 0, 8'h00, 8'h05, 8'h07, 1'b0};
    tbl[9]  = '{5'h1A, 8'h00, 1'b0, 1'b0, 1, 0, 8'h00, 8'h05, 8'h07, 1'b0};
    tbl[10] = '{5'h1D, 8'h00, 1'b0, CF, CF ? 2 : 1, 0, 8'h00, 8'h05, 8'h07, 1'b0};
    tbl[11] = '{5'h1F, 8'hFF, 1'b0, 1'b1, 2, 1, 8'hFF, 8'h05, 8'h07, 1'b0};
    tbl[12] = '{5'h1F, 8'h01, 1'b0, 1'b1, 2, 2, 8'h01, 8'h05, 8'h07, 1'b0};
    tbl[13] = '{5'h00, 8'h00, 1'b0, 1'b1, 7, 1, 8'h00, 8'hFF, 8'h01, CF};
    tbl[14] = '{5'h1F, 8'h02, 1'b0, 1'b1, 2, 2, 8'h02, 8'hFF, 8'h01, CF};
    tbl[15] = '{5'h1D, 8'h00, 1'b0, CF, CF ? 2 : 1, 2, 8'h02, 8'hFF, 8'h01, 1'b0};
    tbl[16] = '{5'h01, 8'h00, 1'b1, 1'b0, 7, 0, 8'h00, 8'h00, 8'h02, CF};
    tbl[17] = '{5'h1F, 8'h5A, 1'b0, 1'b1, 2, 1, 8'h5A, 8'h00, 8'h02, CF};
    tbl[18] = '{5'h18, 8'h00, 1'b0, 1'b0, 1, 1, 8'h5A, 8'h00, 8'h02, CF};

    rstn        = 1'b0;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_imm   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_strobes", 32'({stk_push, stk_pop, ld_tmp1, ld_tmp2, done, err}), 32'd0);
    chk("rst_alu_din", 32'({alu_op, stk_din}), 32'd0);
    chk("rst_carry", 32'(carry_flag), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run(tbl[i].op, tbl[i].imm, tbl[i].full, lat, gd, ge);
      chk($sformatf("v%0d_done", i), 32'({gd, ge}), tbl[i].exp_done ? 32'b10 : 32'b01);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("v%0d_depth", i), 32'(sp), 32'(tbl[i].exp_depth));
      if (tbl[i].exp_depth > 0)
        chk($sformatf("v%0d_top", i), 32'(mem[sp-1]), 32'(tbl[i].exp_top));
      chk($sformatf("v%0d_tmp", i), 32'({t1, t2}), 32'({tbl[i].exp_t1, tbl[i].exp_t2}));
      chk($sformatf("v%0d_carry", i), 32'(carry_flag), 32'(tbl[i].exp_c));
    end

    // Reset in the middle of a binary op, while LD_A is active
    run(5'h1F, 8'h33, 1'b0, lat, gd, ge);
    @(negedge clk);
    instr_op    = 5'h00;
    instr_valid = 1'b1;
    w = 0;
    while (!ld_tmp1 && w < 20) begin
      @(negedge clk);
      instr_valid = 1'b0;
      w++;
    end
    chk("midrst_reach_lda", 32'(w < 20), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_strobes", 32'({stk_push, stk_pop, ld_tmp1, ld_tmp2, done, err}), 32'd0);
    chk("midrst_alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_quiet%0d", k), 32'({done, err, stk_push, instr_ready}), 32'b0001);
    end
    chk("midrst_carry", 32'(carry_flag), 32'd0);

    // Illegal op with instr_valid held: accepts only from IDLE, err each time
    exp_rdy = 4'b0101;
    exp_err = 4'b1010;
    @(negedge clk);
    instr_op    = 5'h1A;
    instr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("held_ready%0d", k), 32'(instr_ready), 32'(exp_rdy[k]));
      chk($sformatf("held_err%0d", k), 32'(err), 32'(exp_err[k]));
      chk($sformatf("held_strobe%0d", k), 32'({stk_push, stk_pop, ld_tmp1, ld_tmp2, done}), 32'd0);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);

    chk("both_strobes", 32'(both_cnt), 32'd0);
    chk("push_when_full", 32'(bad_push), 32'd0);
    chk("pop_when_empty", 32'(bad_pop), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
